// File: rtl/hs_pkg.sv
// Shared types and constants for the req/ack slave register file.
package hs_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        ERR
    } hs_state_e;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam int DEF_DATA_W = 4;
    localparam int DEF_DEPTH  = 4;

endpackage

// File: rtl/hs_sync.sv
// N-flop level synchroniser for an asynchronous single-bit input, cleared by reset.
module hs_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/hs_slave_regfile.sv
// Four-phase req/ack slave on a tri-state bus fronting a DEPTH-entry register file.
// Optional ACK timeout (ERR state, sticky timeout_err) enabled by defining HS_TIMEOUT_EN.
module hs_slave_regfile
    import hs_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 16,
    localparam int ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              req,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    inout  wire  [DATA_W-1:0] data_bus,
    output logic              ack,
    output logic [DATA_W-1:0] rcvd_data,
    output logic              xfer_done,
    output logic              timeout_err,
    input  logic              loc_we,
    input  logic [ADDR_W-1:0] loc_addr,
    input  logic [DATA_W-1:0] loc_data
);

    logic              req_s;
    hs_state_e         state_q;
    logic              ack_q;
    logic              drive_en_q;
    logic              xfer_done_q;
    logic [DATA_W-1:0] dout_q;
    logic [DATA_W-1:0] rcvd_q;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    logic              accept;
    logic              addr_ok;
    logic              loc_ok;
    logic              bus_wr;
    logic [DATA_W-1:0] rd_val;

    hs_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (req),
        .q_o   (req_s)
    );

    assign accept  = (state_q == IDLE) && req_s && start;
    assign addr_ok = int'(addr) < DEPTH;
    assign loc_ok  = int'(loc_addr) < DEPTH;
    assign bus_wr  = accept && (rw == RW_WRITE) && addr_ok;
    assign rd_val  = addr_ok ? mem_q[addr] : '0;

    // Bus write is applied last so it overrides a same-address local write.
    always_comb begin
        mem_d = mem_q;
        if (loc_we && loc_ok) begin
            mem_d[loc_addr] = loc_data;
        end
        if (bus_wr) begin
            mem_d[addr] = data_bus;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

`ifdef HS_TIMEOUT_EN
    localparam int              TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] to_cnt_q;
    logic            timeout_err_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ack_q       <= 1'b0;
            drive_en_q  <= 1'b0;
            xfer_done_q <= 1'b0;
            dout_q      <= '0;
            rcvd_q      <= '0;
`ifdef HS_TIMEOUT_EN
            to_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            xfer_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= ACK;
                        ack_q   <= 1'b1;
`ifdef HS_TIMEOUT_EN
                        to_cnt_q      <= '0;
                        timeout_err_q <= 1'b0;
`endif
                        if (rw == RW_READ) begin
                            dout_q     <= rd_val;
                            drive_en_q <= 1'b1;
                        end else begin
                            rcvd_q <= data_bus;
                        end
                    end
                end
                ACK: begin
                    if (!req_s) begin
                        state_q     <= IDLE;
                        ack_q       <= 1'b0;
                        drive_en_q  <= 1'b0;
                        xfer_done_q <= 1'b1;
                    end
`ifdef HS_TIMEOUT_EN
                    else if (to_cnt_q == TO_LAST) begin
                        state_q       <= ERR;
                        ack_q         <= 1'b0;
                        drive_en_q    <= 1'b0;
                        timeout_err_q <= 1'b1;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
`endif
                end
                ERR: begin
                    if (!req_s) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_bus  = drive_en_q ? dout_q : 'z;
    assign ack       = ack_q;
    assign rcvd_data = rcvd_q;
    assign xfer_done = xfer_done_q;

`ifdef HS_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule
